// File: rtl/s12_pkg.sv
// rtl/s12_pkg.sv - shared constants, FSM encoding and frame helper for the S1/S2 serial link
package s12_pkg;

    localparam int NWORDS  = 18;
    localparam int NFRAMES = 8;
    localparam int AW      = 3;
    localparam int RAW     = 5;
    localparam int FRAME_W = AW + NWORDS;
    localparam int BCW     = 5;
    localparam int FCW     = 4;

    localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_W - 1);
    localparam logic [RAW-1:0] LAST_WORD  = RAW'(NWORDS - 1);
    localparam logic [RAW-1:0] LOAD_LAST  = RAW'(NWORDS);
    localparam logic [FCW-1:0] FRAME_TERM = FCW'(NFRAMES);

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } s1_state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [AW-1:0]     addr,
                                                      input logic [NWORDS-1:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/s1_frame_ser.sv
// rtl/s1_frame_ser.sv - shifts one 21-bit frame out MSB-first on sen/sd, pulses frame_end on the last bit
module s1_frame_ser
    import s12_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               sen,
    output logic               sd,
    output logic               frame_end
);

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic               busy_q, busy_d;
    logic               sen_q, sen_d;
    logic               sd_q, sd_d;

    assign frame_end = busy_q && (bit_cnt_q == LAST_BIT);
    assign sen       = sen_q;
    assign sd        = sd_q;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        sen_d     = sen_q;
        sd_d      = sd_q;
        if (load) begin
            shreg_d   = frame_data;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            sen_d     = 1'b0;
            sd_d      = frame_data[FRAME_W-1];
        end else if (busy_q) begin
            if (bit_cnt_q == LAST_BIT) begin
                // Line goes idle on the edge after the 21st bit has been held a full cycle
                bit_cnt_d = '0;
                busy_d    = 1'b0;
                sen_d     = 1'b1;
                sd_d      = 1'b0;
            end else begin
                shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BCW'(1);
                sd_d      = shreg_q[FRAME_W-2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            sen_q     <= 1'b1;
            sd_q      <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            sen_q     <= sen_d;
            sd_q      <= sd_d;
        end
    end

endmodule

// File: rtl/s1_serial_tx.sv
// rtl/s1_serial_tx.sv - reads RB1 once after reset, transposes it and sends 8 address-tagged frames
module s1_serial_tx
    import s12_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic               RB1_RW,
    output logic [RAW-1:0]     RB1_A,
    input  logic [NFRAMES-1:0] RB1_Q,
    output logic               sen,
    output logic               sd,
    output logic               S1_done
);

    s1_state_t                       state_q, state_d;
    logic [RAW-1:0]                  load_cnt_q, load_cnt_d;
    logic [FCW-1:0]                  frame_cnt_q, frame_cnt_d;
    logic [RAW-1:0]                  rb1_a_q, rb1_a_d;
    logic                            rb1_rw_q, rb1_rw_d;
    logic                            done_q, done_d;
    logic [NFRAMES-1:0][NWORDS-1:0]  tbuf_q, tbuf_d;

    logic [RAW-1:0]                  cap_idx;
    logic                            ser_load;
    logic [FRAME_W-1:0]              ser_frame;
    logic                            ser_frame_end;

    assign RB1_RW  = rb1_rw_q;
    assign RB1_A   = rb1_a_q;
    assign S1_done = done_q;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        frame_cnt_d = frame_cnt_q;
        rb1_a_d     = rb1_a_q;
        rb1_rw_d    = 1'b1;
        done_d      = done_q;
        tbuf_d      = tbuf_q;
        ser_load    = 1'b0;
        ser_frame   = make_frame(frame_cnt_q[AW-1:0], tbuf_q[frame_cnt_q[AW-1:0]]);
        cap_idx     = load_cnt_q - RAW'(1);
        case (state_q)
            LOAD: begin
                load_cnt_d = load_cnt_q + RAW'(1);
                if (load_cnt_q < LAST_WORD)
                    rb1_a_d = rb1_a_q + RAW'(1);
                // RB1_Q lags the address by one cycle, so word n lands while load_cnt is n+1
                if (load_cnt_q != '0) begin
                    for (int j = 0; j < NFRAMES; j++)
                        tbuf_d[j][cap_idx] = RB1_Q[j];
                end
                if (load_cnt_q == LOAD_LAST) begin
                    state_d    = SEND;
                    load_cnt_d = '0;
                    ser_load   = 1'b1;
                    // Word 17 is still on RB1_Q this cycle; bypass it into frame 0
                    ser_frame  = make_frame('0, {RB1_Q[0], tbuf_q[0][NWORDS-2:0]});
                end
            end
            SEND: begin
                if (ser_frame_end) begin
                    state_d     = GAP;
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                end
            end
            GAP: begin
                if (frame_cnt_q == FRAME_TERM) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = SEND;
                    ser_load = 1'b1;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            frame_cnt_q <= '0;
            rb1_a_q     <= '0;
            rb1_rw_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rb1_a_q     <= rb1_a_d;
            rb1_rw_q    <= rb1_rw_d;
            done_q      <= done_d;
        end
    end

    // Transpose buffer is fully rewritten before use, so it carries no reset
    always_ff @(posedge clk) begin
        tbuf_q <= tbuf_d;
    end

    s1_frame_ser u_ser (
        .clk        (clk),
        .rst_n      (rst),
        .load       (ser_load),
        .frame_data (ser_frame),
        .sen        (sen),
        .sd         (sd),
        .frame_end  (ser_frame_end)
    );

endmodule

// File: tb/tb_s1_serial_tx.sv
// tb/tb_s1_serial_tx.sv - directed self-checking bench for s1_serial_tx
module tb_s1_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       RB1_RW;
    logic [4:0] RB1_A;
    logic [7:0] rb1_q = 8'h00;
    logic       sen;
    logic       sd;
    logic       S1_done;

    logic [7:0] mem [18];

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] frames [16];
    int          runs   [16];
    int          gaps   [16];
    int          nframes, run_len, gap_len, first_low, done_cycle;
    int          rw_bad, a_bad, sd_bad, post_done_bad, done_drop;
    logic [20:0] cur;
    logic        prev_sen;

    logic [17:0] walk_exp [8] = '{18'h10101, 18'h20202, 18'h00404, 18'h00808,
                                  18'h01010, 18'h02020, 18'h04040, 18'h08080};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RB1_A < 5'd18) rb1_q <= mem[RB1_A];
        else               rb1_q <= 8'h00;
    end

    s1_serial_tx dut (
        .clk     (clk),
        .rst     (rst),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .RB1_Q   (rb1_q),
        .sen     (sen),
        .sd      (sd),
        .S1_done (S1_done)
    );

    function automatic logic [20:0] exp_frame(input int j);
        logic [17:0] d;
        for (int n = 0; n < 18; n++) d[n] = mem[n][j];
        return {3'(j), d};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clear_obs();
        nframes = 0; run_len = 0; gap_len = 0; first_low = -1; done_cycle = -1;
        rw_bad = 0; a_bad = 0; sd_bad = 0; post_done_bad = 0; done_drop = 0;
        cur = '0; prev_sen = 1'b1;
    endtask

    // Observes ncycles cycles after reset release; call at the releasing negedge
    task automatic capture(input int ncycles);
        for (int c = 1; c <= ncycles; c++) begin
            @(negedge clk);
            if (RB1_RW !== 1'b1) rw_bad++;
            if (RB1_A > 5'd17) a_bad++;
            if (c <= 18 && RB1_A !== 5'((c > 17) ? 17 : c)) a_bad++;
            if (sen === 1'b1 && sd !== 1'b0) sd_bad++;
            if (sen === 1'b0) begin
                if (prev_sen) begin
                    if (nframes > 0) gaps[nframes-1] = gap_len;
                    if (first_low < 0) first_low = c;
                    run_len = 0;
                    cur = '0;
                end
                cur = {cur[19:0], sd};
                run_len++;
            end else begin
                if (!prev_sen && nframes < 16) begin
                    frames[nframes] = cur;
                    runs[nframes] = run_len;
                    nframes++;
                    gap_len = 0;
                end
                gap_len++;
            end
            if (done_cycle >= 0 && S1_done !== 1'b1) done_drop++;
            if (S1_done === 1'b1 && done_cycle < 0) done_cycle = c;
            if (done_cycle >= 0 && sen !== 1'b1) post_done_bad++;
            prev_sen = sen;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({RB1_RW, RB1_A, sen, sd, S1_done} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got rw=%b a=%0d sen=%b sd=%b done=%b, expected rw=1 a=0 sen=1 sd=0 done=0",
                     RB1_RW, RB1_A, sen, sd, S1_done);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({RB1_RW, RB1_A, sen, sd, S1_done} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_held: got rw=%b a=%0d sen=%b sd=%b done=%b, expected rw=1 a=0 sen=1 sd=0 done=0",
                     RB1_RW, RB1_A, sen, sd, S1_done);
        end
    endtask

    task automatic test_all_ones();
        for (int n = 0; n < 18; n++) mem[n] = 8'hFF;
        clear_obs();
        do_reset();
        capture(210);
        n_checks++;
        if (done_cycle != 195) begin
            n_fail++; $display("FAIL ones_done_cycle: got %0d expected 195", done_cycle);
        end
        n_checks++;
        if (nframes != 8) begin
            n_fail++; $display("FAIL ones_nframes: got %0d expected 8", nframes);
        end
        for (int j = 0; j < 8 && j < nframes; j++) begin
            n_checks++;
            if (frames[j] !== {3'(j), 18'h3FFFF}) begin
                n_fail++; $display("FAIL ones_frame%0d: got %h expected %h", j, frames[j], {3'(j), 18'h3FFFF});
            end
        end
        n_checks++;
        if (rw_bad != 0 || a_bad != 0) begin
            n_fail++; $display("FAIL ones_rb1_bus: got rw_bad=%0d a_bad=%0d expected 0 0", rw_bad, a_bad);
        end
        n_checks++;
        if (done_drop != 0) begin
            n_fail++; $display("FAIL ones_done_sticky: got %0d drops expected 0", done_drop);
        end
    endtask

    task automatic test_walking();
        for (int n = 0; n < 18; n++) mem[n] = 8'h01 << (n % 8);
        clear_obs();
        do_reset();
        capture(200);
        n_checks++;
        if (nframes != 8) begin
            n_fail++; $display("FAIL walk_nframes: got %0d expected 8", nframes);
        end
        for (int j = 0; j < 8 && j < nframes; j++) begin
            n_checks++;
            if (frames[j] !== {3'(j), walk_exp[j]}) begin
                n_fail++; $display("FAIL walk_frame%0d: got %h expected %h", j, frames[j], {3'(j), walk_exp[j]});
            end
        end
    endtask

    task automatic test_framing();
        for (int n = 0; n < 18; n++) mem[n] = 8'(n * 37 + 5);
        clear_obs();
        do_reset();
        capture(230);
        n_checks++;
        if (first_low != 19) begin
            n_fail++; $display("FAIL frame_first_low: got cycle %0d expected 19", first_low);
        end
        n_checks++;
        if (nframes != 8) begin
            n_fail++; $display("FAIL frame_low_runs: got %0d expected 8", nframes);
        end
        for (int j = 0; j < 8 && j < nframes; j++) begin
            n_checks++;
            if (runs[j] != 21) begin
                n_fail++; $display("FAIL frame_run%0d: got %0d low cycles expected 21", j, runs[j]);
            end
            if (j < 7) begin
                n_checks++;
                if (gaps[j] != 1) begin
                    n_fail++; $display("FAIL frame_gap%0d: got %0d high cycles expected 1", j, gaps[j]);
                end
            end
        end
        n_checks++;
        if (post_done_bad != 0 || sd_bad != 0) begin
            n_fail++; $display("FAIL frame_idle: got post_done_bad=%0d sd_bad=%0d expected 0 0", post_done_bad, sd_bad);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 18; n++) mem[n] = 8'($urandom);
        clear_obs();
        do_reset();
        capture(200);
        n_checks++;
        if (done_cycle != 195) begin
            n_fail++; $display("FAIL rand_done_cycle: got %0d expected 195", done_cycle);
        end
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (j >= nframes || frames[j] !== exp_frame(j)) begin
                n_fail++; $display("FAIL rand_frame%0d: got %h expected %h", j, frames[j], exp_frame(j));
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 18; n++) mem[n] = 8'($urandom);
        clear_obs();
        do_reset();
        capture(95);
        n_checks++;
        if (nframes != 3 || sen !== 1'b0 || run_len != 11) begin
            n_fail++; $display("FAIL midrst_position: got frames=%0d sen=%b run=%0d expected 3 0 11", nframes, sen, run_len);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({sen, sd, S1_done} !== 3'b100) begin
            n_fail++; $display("FAIL midrst_async: got sen=%b sd=%b done=%b expected 1 0 0", sen, sd, S1_done);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        capture(200);
        n_checks++;
        if (done_cycle != 195 || nframes != 8) begin
            n_fail++; $display("FAIL midrst_rerun: got done=%0d frames=%0d expected 195 8", done_cycle, nframes);
        end
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (j >= nframes || frames[j] !== exp_frame(j)) begin
                n_fail++; $display("FAIL midrst_frame%0d: got %h expected %h", j, frames[j], exp_frame(j));
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 18; n++) mem[n] = 8'h00;
        test_reset();
        test_all_ones();
        test_walking();
        test_framing();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
